// File: rtl/qbus_if.sv
// Qbus pin bundle shared by the bus-master engine and whatever models or drives the bus side.
// Signals ending in f are active-low as received; signals ending in g are true-polarity gate drives.
interface qbus_if;
  logic [21:0] BDALf_IN;
  logic [21:0] BDALf_OUT;
  logic [21:0] BDALf_OE;
  logic        Outbound;
  logic        BRPLYf;
  logic        BSYNCf;
  logic        BDMGIf;
  logic        BDMRg;
  logic        BSACKg;
  logic        BSYNCg;
  logic        BDINg;
  logic        BDOUTg;
  logic        BDMGOg;

  modport master (
    input  BDALf_IN, BRPLYf, BSYNCf, BDMGIf,
    output BDALf_OUT, BDALf_OE, Outbound, BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BDMGOg
  );

  modport slave (
    output BDALf_IN, BRPLYf, BSYNCf, BDMGIf,
    input  BDALf_OUT, BDALf_OE, Outbound, BDMRg, BSACKg, BSYNCg, BDINg, BDOUTg, BDMGOg
  );
endinterface

// File: rtl/qbus_dma_master.sv
// Single-word Qbus DMA master: arbitrates with DMR/DMG/SACK, runs one DATI or DATO per start
// pulse, and aborts with nxm when the bus stops answering.
module qbus_dma_master #(
  parameter int SYNC_STAGES    = 2,
  parameter int ASETUP_CYCLES  = 8,
  parameter int DSETUP_CYCLES  = 8,
  parameter int DHOLD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [21:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        nxm,
  output logic [15:0] rdata,
  qbus_if.master      bus
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_REQ       = 4'd1;
  localparam logic [3:0] S_WAITBUS   = 4'd2;
  localparam logic [3:0] S_ADDR      = 4'd3;
  localparam logic [3:0] S_SYNC      = 4'd4;
  localparam logic [3:0] S_DIN       = 4'd5;
  localparam logic [3:0] S_DSETUP    = 4'd6;
  localparam logic [3:0] S_DOUT      = 4'd7;
  localparam logic [3:0] S_DOHOLD    = 4'd8;
  localparam logic [3:0] S_WAITNRPLY = 4'd9;
  localparam logic [3:0] S_RELEASE   = 4'd10;

  logic [SYNC_STAGES-1:0] rply_sr, dmg_sr, sync_sr;
  logic                   reply, grant, bus_sync;

  logic [3:0]  state;
  logic [15:0] cnt;
  logic        wr_q;
  logic [21:0] addr_q;
  logic [15:0] wdata_q;
  logic        timed_state, timed_out;

  // Synchronisers idle at the negated (high) level so reset never looks like a grant or reply.
  always_ff @(posedge clock) begin
    if (reset) begin
      rply_sr <= '1;
      dmg_sr  <= '1;
      sync_sr <= '1;
    end else begin
      rply_sr <= {rply_sr[SYNC_STAGES-2:0], bus.BRPLYf};
      dmg_sr  <= {dmg_sr[SYNC_STAGES-2:0],  bus.BDMGIf};
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], bus.BSYNCf};
    end
  end

  assign reply    = ~rply_sr[SYNC_STAGES-1];
  assign grant    = ~dmg_sr[SYNC_STAGES-1];
  assign bus_sync = ~sync_sr[SYNC_STAGES-1];

  assign timed_state = (state == S_REQ) || (state == S_WAITBUS) || (state == S_DIN) ||
                       (state == S_DOUT) || (state == S_WAITNRPLY);
  assign timed_out   = timed_state && (cnt == 16'(TIMEOUT_CYCLES - 1));

  // NOTE: state and outputs use non-blocking assignments so every branch sees pre-edge values;
  // the abort block after the case relies on that to override the normal transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      nxm           <= 1'b0;
      rdata         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.BDALf_OUT <= '0;
      bus.BDALf_OE  <= '0;
      bus.Outbound  <= 1'b0;
      bus.BDMRg     <= 1'b0;
      bus.BSACKg    <= 1'b0;
      bus.BSYNCg    <= 1'b0;
      bus.BDINg     <= 1'b0;
      bus.BDOUTg    <= 1'b0;
      bus.BDMGOg    <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt + 16'd1;
      if (state != S_IDLE) bus.BDMGOg <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt        <= '0;
          bus.BDMGOg <= grant;
          if (start) begin
            wr_q       <= write;
            addr_q     <= addr & ~22'd1;
            wdata_q    <= wdata;
            nxm        <= 1'b0;
            busy       <= 1'b1;
            bus.BDMGOg <= 1'b0;
            bus.BDMRg  <= 1'b1;
            state      <= S_REQ;
          end
        end
        // SACK goes out as soon as we own the grant; mastership waits for the bus to go quiet.
        S_REQ: if (grant) begin
          bus.BSACKg <= 1'b1;
          state      <= S_WAITBUS;
          cnt        <= '0;
        end
        S_WAITBUS: if (!bus_sync && !reply) begin
          bus.BDMRg     <= 1'b0;
          bus.BDALf_OUT <= addr_q;
          bus.BDALf_OE  <= '1;
          bus.Outbound  <= 1'b1;
          state         <= S_ADDR;
          cnt           <= '0;
        end
        S_ADDR: if (cnt == 16'(ASETUP_CYCLES - 1)) begin
          bus.BSYNCg <= 1'b1;
          state      <= S_SYNC;
          cnt        <= '0;
        end
        S_SYNC: if (cnt == 16'(DHOLD_CYCLES - 1)) begin
          cnt <= '0;
          if (wr_q) begin
            bus.BDALf_OUT <= {6'b0, wdata_q};
            state         <= S_DSETUP;
          end else begin
            bus.BDALf_OE  <= '0;
            bus.Outbound  <= 1'b0;
            bus.BDALf_OUT <= '0;
            bus.BDINg     <= 1'b1;
            state         <= S_DIN;
          end
        end
        S_DIN: if (reply) begin
          rdata     <= 16'(~bus.BDALf_IN);
          bus.BDINg <= 1'b0;
          state     <= S_WAITNRPLY;
          cnt       <= '0;
        end
        S_DSETUP: if (cnt == 16'(DSETUP_CYCLES - 1)) begin
          bus.BDOUTg <= 1'b1;
          state      <= S_DOUT;
          cnt        <= '0;
        end
        S_DOUT: if (reply) begin
          bus.BDOUTg <= 1'b0;
          state      <= S_DOHOLD;
          cnt        <= '0;
        end
        S_DOHOLD: if (cnt == 16'(DHOLD_CYCLES - 1)) begin
          state <= S_WAITNRPLY;
          cnt   <= '0;
        end
        S_WAITNRPLY: if (!reply) begin
          bus.BSYNCg    <= 1'b0;
          bus.BDALf_OE  <= '0;
          bus.Outbound  <= 1'b0;
          bus.BDALf_OUT <= '0;
          state         <= S_RELEASE;
          cnt           <= '0;
        end
        S_RELEASE: begin
          bus.BSACKg <= 1'b0;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
          cnt        <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase

      // Non-existent memory / lost grant: drop every drive and finish through RELEASE.
      if (timed_out) begin
        nxm           <= 1'b1;
        bus.BDINg     <= 1'b0;
        bus.BDOUTg    <= 1'b0;
        bus.BSYNCg    <= 1'b0;
        bus.BDMRg     <= 1'b0;
        bus.BDALf_OE  <= '0;
        bus.Outbound  <= 1'b0;
        bus.BDALf_OUT <= '0;
        state         <= S_RELEASE;
        cnt           <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qbus_dma_master.sv
// Directed bench for qbus_dma_master: a small Qbus arbiter/memory model answers the engine,
// and a scoreboard of expected transfer results is checked on every done pulse.
module tb_qbus_dma_master;

  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, done, nxm;
  logic [15:0] rdata;

  qbus_if bus ();

  qbus_dma_master dut (
    .clock (clk),
    .reset (reset),
    .start (start),
    .write (write),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .nxm   (nxm),
    .rdata (rdata),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bus environment controls, driven only by the stimulus block.
  logic        tb_dmg = 1'b0;
  logic        tb_bsync = 1'b0;
  logic        rply_en = 1'b0;
  logic [15:0] resp_data = '0;

  // Arbiter/memory model state.
  logic model_dmg = 1'b0;
  logic model_rply = 1'b0;
  int   gcnt = 0;
  int   rcnt = 0;

  assign bus.BDMGIf   = ~(model_dmg | tb_dmg);
  assign bus.BSYNCf   = ~tb_bsync;
  assign bus.BRPLYf   = ~model_rply;
  assign bus.BDALf_IN = ~{6'b0, resp_data};

  // Grant 5 clocks after DMR, drop it on SACK; reply 3 clocks after DIN/DOUT, drop with them.
  always @(negedge clk) begin
    if (reset) begin
      model_dmg = 1'b0; model_rply = 1'b0; gcnt = 0; rcnt = 0;
    end else begin
      if (bus.BSACKg || !bus.BDMRg) begin
        model_dmg = 1'b0; gcnt = 0;
      end else if (gcnt >= 5) model_dmg = 1'b1;
      else gcnt++;
      if (!bus.BDINg && !bus.BDOUTg) begin
        model_rply = 1'b0; rcnt = 0;
      end else if (rply_en) begin
        if (rcnt >= 3) model_rply = 1'b1;
        else rcnt++;
      end
    end
  end

  // Captures the address at BSYNC rise and data at BDOUT rise, with how long each was stable.
  logic [21:0] prev_out = '0;
  logic        prev_sync = 1'b0, prev_dout = 1'b0;
  int          stable = 0, asetup_seen = 0, dsetup_seen = 0;
  logic [21:0] cap_addr = '0;
  logic [15:0] cap_wdata = '0;

  always @(negedge clk) begin
    if ((bus.BDALf_OE == 22'h3FFFFF) && (bus.BDALf_OUT == prev_out)) stable++;
    else stable = 0;
    if (bus.BSYNCg && !prev_sync) begin cap_addr = bus.BDALf_OUT; asetup_seen = stable; end
    if (bus.BDOUTg && !prev_dout) begin cap_wdata = bus.BDALf_OUT[15:0]; dsetup_seen = stable; end
    prev_out  = bus.BDALf_OUT;
    prev_sync = bus.BSYNCg;
    prev_dout = bus.BDOUTg;
  end

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        nxm;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.BDMRg;
      1:       return bus.BSACKg;
      2:       return bus.BSYNCg;
      3:       return bus.BDINg;
      4:       return bus.BDOUTg;
      default: return done;
    endcase
  endfunction

  task automatic wait_until(input int sel, input string tag);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_time"}, 32'(n < LIMIT), 1);
  endtask

  task automatic do_start(input logic wr, input logic [21:0] a, input logic [15:0] d,
                          input logic push, input logic [15:0] exp_rd, input logic exp_nxm);
    exp_t e;
    start = 1'b1; write = wr; addr = a; wdata = d;
    if (push) begin
      e.wr = wr; e.addr = {a[21:1], 1'b0}; e.wdata = d; e.rdata = exp_rd; e.nxm = exp_nxm;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    wait_until(5, {tag, "_done"});
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rdata, e.rdata);
      check({tag, "_nxm"}, nxm, e.nxm);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_bus_addr"}, cap_addr, e.addr);
      check({tag, "_asetup"}, 32'(asetup_seen >= 8), 1);
      if (e.wr) begin
        check({tag, "_bus_wdata"}, cap_wdata, e.wdata);
        check({tag, "_dsetup"}, 32'(dsetup_seen >= 8), 1);
      end
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  function automatic logic [6:0] drives();
    return {bus.BDMRg, bus.BSACKg, bus.BSYNCg, bus.BDINg, bus.BDOUTg, bus.BDMGOg, bus.Outbound};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_drives", drives(), 0);
    check("reset_oe", bus.BDALf_OE, 0);
    check("reset_out", bus.BDALf_OUT, 0);
    check("reset_status", {busy, done, nxm}, 0);
    check("reset_rdata", rdata, 0);

    // Grant passes through while idle.
    tb_dmg = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_dmgo_on", bus.BDMGOg, 1);
    tb_dmg = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_dmgo_off", bus.BDMGOg, 0);

    // DATI with normal reply; a start during the transfer must be ignored.
    rply_en = 1'b1;
    resp_data = 16'o123456;
    do_start(1'b0, 22'o1000, 16'h0000, 1'b1, 16'o123456, 1'b0);
    wait_until(0, "dati_dmr");
    check("dati_busy", busy, 1);
    do_start(1'b1, 22'o7776, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    wait_until(1, "dati_sack");
    check("dati_dmgo_blocked", bus.BDMGOg, 0);
    wait_until(2, "dati_sync");
    check("dati_sync_phase", {bus.BSACKg, bus.BDMRg, bus.BDINg, bus.BDOUTg}, 4'b1000);
    check("dati_addr_oe", bus.BDALf_OE, 22'h3FFFFF);
    wait_until(3, "dati_din");
    check("dati_din_phase", {bus.BSYNCg, bus.Outbound}, 2'b10);
    check("dati_din_oe", bus.BDALf_OE, 0);
    wait_done("dati");

    // DATO with normal reply.
    do_start(1'b1, 22'o2002, 16'hBEEF, 1'b1, 16'o123456, 1'b0);
    wait_until(4, "dato_dout");
    check("dato_no_din", bus.BDINg, 0);
    check("dato_data", bus.BDALf_OUT, 22'h00BEEF);
    wait_done("dato");

    // DATI to non-existent memory: timeout in DIN.
    rply_en = 1'b0;
    do_start(1'b0, 22'o4000, 16'h0000, 1'b1, 16'o123456, 1'b1);
    wait_done("nxm");
    check("nxm_drives", drives(), 0);
    check("nxm_oe", bus.BDALf_OE, 0);
    check("nxm_sticky", nxm, 1);

    // Next start clears nxm; reset lands while in DOUT.
    do_start(1'b1, 22'o2222, 16'h1234, 1'b0, 16'h0, 1'b0);
    check("start_clears_nxm", {busy, nxm}, 2'b10);
    wait_until(4, "rst_dout");
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_drives", drives(), 0);
    check("rst_mid_oe", bus.BDALf_OE, 0);
    check("rst_mid_status", {busy, done, nxm}, 0);
    reset = 1'b0;
    rply_en = 1'b1;
    @(negedge clk);

    // Another master still holds BSYNC after our grant.
    tb_bsync = 1'b1;
    resp_data = 16'h5A5A;
    do_start(1'b0, 22'o3000, 16'h0000, 1'b1, 16'h5A5A, 1'b0);
    wait_until(1, "busy_sack");
    check("busy_no_sync", bus.BSYNCg, 0);
    repeat (20) @(negedge clk);
    check("busy_wait_phase", {bus.BSACKg, bus.BSYNCg, bus.Outbound}, 3'b100);
    tb_bsync = 1'b0;
    wait_done("busybus");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
